fp_add_pipe: RTL
================

# fp_add_pipe

Pipelined, parametrised floating-point adder/subtractor with a valid/ready stream interface, successor to the combinational FP8 adder in the top-level Tiny Tapeout wrapper. Accepts one operand pair per cycle, produces IEEE-style round-to-nearest-even results after a fixed three-stage pipeline, and raises exception flags. Sits between the input-capture logic and the output/display logic. Global stall on output backpressure.

## Interface

- EXP_WIDTH, 5, exponent field width (≥3); bias = 2^(EXP_WIDTH-1)-1
- MAN_WIDTH, 2, stored mantissa field width (≥1)
- WIDTH, 1+EXP_WIDTH+MAN_WIDTH, derived localparam (not overridable), total word width
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operand pair present
- in_ready  out  1  pipeline can accept this cycle
- in_a  in  WIDTH  operand A {sign, exp, man}
- in_b  in  WIDTH  operand B
- in_sub  in  1  0: A+B, 1: A−B (B sign inverted at entry)
- out_valid  out  1  result present
- out_ready  in  1  downstream accepts result
- out_data  out  WIDTH  result
- out_flags  out  3  {invalid, overflow, underflow}, qualified by out_valid

## Operation

- Encoding: exp all-ones & man=0 → ±inf; exp all-ones & man≠0 → NaN; exp=0 → zero/subnormal (hidden bit 0, effective exponent 1); else normal.
- Stage 1 (unpack/align): classify operands, apply in_sub, swap so larger magnitude is first, right-shift smaller significand by exponent difference keeping guard, round, sticky bits; shifts ≥ MAN_WIDTH+3 collapse to sticky only.
- Stage 2 (add): add or subtract significands per effective sign; result sign = sign of larger magnitude.
- Stage 3 (normalise/round/pack): leading-zero normalise (stop at subnormal boundary), round-to-nearest-even on guard/round/sticky, renormalise on mantissa carry-out, pack, resolve specials.
- Special rules, priority order:
  - any NaN input, or inf + (−inf) after in_sub → canonical NaN {0, all-ones, 1, 0…0}, invalid=1.
  - either input inf → that inf, no flags.
  - exact zero result from opposite-signed operands → +0; (−0)+(−0) → −0.
  - rounded exponent ≥ all-ones from finite inputs → ±inf, overflow=1.
  - nonzero result with exp field 0 → underflow=1.
- Flags are per-result, not sticky.

## Timing

- Reset: out_valid=0, out_data=0, out_flags=0, all stage valids 0; in_ready=1 once rst deasserts. Reset mid-flight discards all in-flight results.
- Accept: transfer when in_valid && in_ready at a rising edge.
- Latency: exactly 3 cycles when not stalled; a pair accepted at edge k appears with out_valid=1 after edge k+3.
- Throughput: 1 result/cycle with out_ready held 1.
- Stall: in_ready = !(out_valid && !out_ready). While stalled all three stages hold; out_data/out_flags stable while out_valid && !out_ready.
- Bubbles propagate as invalid stages; a stall occurs only when the output slot holds a valid result, so bubbles ahead of it are not collapsed (simple global stall).
- Simultaneous output transfer and input accept in the same cycle permitted; no result lost or duplicated.
- in_a/in_b/in_sub ignored when not accepted.

## Test plan

- Basic (E5M2): 0x3C+0x3C → 0x40 (2.0); 0x3E+0x3E → 0x42 (3.0); 0x3C with in_sub=1, B=0x3C → 0x00, flags 000; all after 3 cycles.
- Rounding ties-to-even: 0x3C+0x30 (1.0+0.125) → 0x3C; 0x3D+0x30 (1.25+0.125) → 0x3E; flags 000.
- Specials: 0x7B+0x7B → 0x7C, overflow=1; 0x7C+0xFC → 0x7E, invalid=1; 0x7C+0x3C → 0x7C; 0x80+0x80 → 0x80; 0x01+0x01 → 0x02, underflow=1.
- Streaming: 16 back-to-back random pairs, out_ready=1 → 16 results in order, one per cycle, first at cycle 3, matching a reference model.
- Backpressure: random out_ready toggling with continuous in_valid → in_ready low exactly when out_valid&&!out_ready; out_data stable while stalled; no drops/duplicates.
- Reset mid-flight: assert rst with 3 results in flight → out_valid=0 immediately (asynchronous), no stale result emitted after release; rerun with EXP_WIDTH=4, MAN_WIDTH=3: 0x38+0x38 → 0x40.

Source files
------------

// File: rtl/fp_add_pipe.sv
// Pipelined IEEE-style floating-point adder/subtractor (round-to-nearest-even) with a valid/ready stream.
// Operand capture register followed by align, add and normalise/round stages; a global stall on output backpressure.
module fp_add_pipe #(
    parameter int EXP_WIDTH = 5,
    parameter int MAN_WIDTH = 2,
    localparam int WIDTH = 1 + EXP_WIDTH + MAN_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [2:0]       out_flags
);

    localparam int SIG_W = MAN_WIDTH + 1;
    localparam int EXT_W = SIG_W + 3;
    localparam int SUM_W = EXT_W + 1;
    localparam int LOW_W = MAN_WIDTH + 3;
    localparam int EXP_MAX = (1 << EXP_WIDTH) - 1;
    localparam logic [EXP_WIDTH-1:0] EXP_ONES = '1;
    localparam logic [MAN_WIDTH-1:0] NAN_MAN = MAN_WIDTH'(1) << (MAN_WIDTH - 1);
    localparam logic [WIDTH-1:0] QNAN = {1'b0, EXP_ONES, NAN_MAN};

    logic stall;
    assign stall    = out_valid && !out_ready;
    assign in_ready = !stall;

    logic             s0_valid;
    logic [WIDTH-1:0] s0_a, s0_b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s0_valid <= 1'b0;
            s0_a     <= '0;
            s0_b     <= '0;
        end else if (!stall) begin
            s0_valid <= in_valid;
            if (in_valid) begin
                s0_a <= in_a;
                s0_b <= {in_b[WIDTH-1] ^ in_sub, in_b[WIDTH-2:0]};
            end
        end
    end

    logic                   a_exp_ones, b_exp_ones, a_nan, b_nan, a_inf, b_inf, spec_nan;
    logic                   swap, big_sign;
    logic [WIDTH-2:0]       big_mag, small_mag;
    logic [EXP_WIDTH-1:0]   big_e, small_e, diff;
    logic [SIG_W-1:0]       small_sig;
    logic [EXT_W-1:0]       big_ext, small_ext;
    logic [EXT_W+LOW_W-1:0] small_wide;

    assign a_exp_ones = (s0_a[WIDTH-2:MAN_WIDTH] == EXP_ONES);
    assign b_exp_ones = (s0_b[WIDTH-2:MAN_WIDTH] == EXP_ONES);
    assign a_nan      = a_exp_ones && (s0_a[MAN_WIDTH-1:0] != '0);
    assign b_nan      = b_exp_ones && (s0_b[MAN_WIDTH-1:0] != '0);
    assign a_inf      = a_exp_ones && (s0_a[MAN_WIDTH-1:0] == '0);
    assign b_inf      = b_exp_ones && (s0_b[MAN_WIDTH-1:0] == '0);
    assign spec_nan   = a_nan || b_nan || (a_inf && b_inf && (s0_a[WIDTH-1] != s0_b[WIDTH-1]));

    assign swap      = s0_b[WIDTH-2:0] > s0_a[WIDTH-2:0];
    assign big_mag   = swap ? s0_b[WIDTH-2:0] : s0_a[WIDTH-2:0];
    assign small_mag = swap ? s0_a[WIDTH-2:0] : s0_b[WIDTH-2:0];
    assign big_sign  = swap ? s0_b[WIDTH-1] : s0_a[WIDTH-1];

    // Subnormals share the effective exponent 1 with the smallest normal.
    assign big_e   = (big_mag[WIDTH-2:MAN_WIDTH] == '0) ? EXP_WIDTH'(1) : big_mag[WIDTH-2:MAN_WIDTH];
    assign small_e = (small_mag[WIDTH-2:MAN_WIDTH] == '0) ? EXP_WIDTH'(1) : small_mag[WIDTH-2:MAN_WIDTH];
    assign diff    = big_e - small_e;

    assign big_ext    = {big_mag[WIDTH-2:MAN_WIDTH] != '0, big_mag[MAN_WIDTH-1:0], 3'b000};
    assign small_sig  = {small_mag[WIDTH-2:MAN_WIDTH] != '0, small_mag[MAN_WIDTH-1:0]};
    assign small_wide = {small_sig, 3'b000, {LOW_W{1'b0}}} >> diff;
    assign small_ext  = (int'(diff) >= LOW_W) ? {{(EXT_W-1){1'b0}}, |small_sig}
                      : {small_wide[EXT_W+LOW_W-1:LOW_W+1], |small_wide[LOW_W:0]};

    logic                 s1_valid, s1_sign, s1_eff_sub, s1_spec, s1_spec_inv;
    logic [EXP_WIDTH-1:0] s1_exp;
    logic [EXT_W-1:0]     s1_big, s1_small;
    logic [WIDTH-1:0]     s1_spec_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid     <= 1'b0;
            s1_sign      <= 1'b0;
            s1_eff_sub   <= 1'b0;
            s1_spec      <= 1'b0;
            s1_spec_inv  <= 1'b0;
            s1_exp       <= '0;
            s1_big       <= '0;
            s1_small     <= '0;
            s1_spec_data <= '0;
        end else if (!stall) begin
            s1_valid     <= s0_valid;
            s1_sign      <= big_sign;
            s1_eff_sub   <= s0_a[WIDTH-1] ^ s0_b[WIDTH-1];
            s1_spec      <= spec_nan || a_inf || b_inf;
            s1_spec_inv  <= spec_nan;
            s1_exp       <= big_e;
            s1_big       <= big_ext;
            s1_small     <= small_ext;
            s1_spec_data <= spec_nan ? QNAN : (a_inf ? s0_a : s0_b);
        end
    end

    logic                 s2_valid, s2_sign, s2_eff_sub, s2_spec, s2_spec_inv;
    logic [EXP_WIDTH-1:0] s2_exp;
    logic [SUM_W-1:0]     s2_sum;
    logic [WIDTH-1:0]     s2_spec_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid     <= 1'b0;
            s2_sign      <= 1'b0;
            s2_eff_sub   <= 1'b0;
            s2_spec      <= 1'b0;
            s2_spec_inv  <= 1'b0;
            s2_exp       <= '0;
            s2_sum       <= '0;
            s2_spec_data <= '0;
        end else if (!stall) begin
            s2_valid     <= s1_valid;
            s2_sign      <= s1_sign;
            s2_eff_sub   <= s1_eff_sub;
            s2_spec      <= s1_spec;
            s2_spec_inv  <= s1_spec_inv;
            s2_exp       <= s1_exp;
            s2_sum       <= s1_eff_sub ? ({1'b0, s1_big} - {1'b0, s1_small})
                                       : ({1'b0, s1_big} + {1'b0, s1_small});
            s2_spec_data <= s1_spec_data;
        end
    end

    int                   lz, sh, e_norm, e_fin;
    logic                 found, rnd;
    logic [EXT_W-1:0]     norm;
    logic [SIG_W:0]       m_rnd;
    logic [MAN_WIDTH-1:0] man_fin;
    logic [WIDTH-1:0]     res_data;
    logic [2:0]           res_flags;

    always_comb begin
        lz        = 0;
        sh        = 0;
        found     = 1'b0;
        norm      = '0;
        e_norm    = int'(s2_exp);
        e_fin     = 0;
        man_fin   = '0;
        res_data  = '0;
        res_flags = 3'b000;
        if (s2_sum[SUM_W-1]) begin
            norm   = {s2_sum[SUM_W-1:2], s2_sum[1] | s2_sum[0]};
            e_norm = e_norm + 1;
        end else begin
            for (int i = EXT_W - 1; i >= 0; i--) begin
                if (!found) begin
                    if (s2_sum[i]) found = 1'b1;
                    else           lz = lz + 1;
                end
            end
            // Never shift below effective exponent 1: the result then stays subnormal.
            sh     = (lz < e_norm - 1) ? lz : e_norm - 1;
            norm   = s2_sum[EXT_W-1:0] << sh;
            e_norm = e_norm - sh;
        end
        rnd   = norm[2] & (norm[1] | norm[0] | norm[3]);
        m_rnd = {1'b0, norm[EXT_W-1:3]} + {{SIG_W{1'b0}}, rnd};
        if (m_rnd[SIG_W]) begin
            e_fin   = e_norm + 1;
            man_fin = m_rnd[MAN_WIDTH:1];
        end else begin
            e_fin   = m_rnd[MAN_WIDTH] ? e_norm : 0;
            man_fin = m_rnd[MAN_WIDTH-1:0];
        end
        if (s2_spec) begin
            res_data  = s2_spec_data;
            res_flags = {s2_spec_inv, 2'b00};
        end else if (s2_sum == '0) begin
            res_data = {s2_sign & ~s2_eff_sub, {(WIDTH-1){1'b0}}};
        end else if (e_fin >= EXP_MAX) begin
            res_data  = {s2_sign, EXP_ONES, {MAN_WIDTH{1'b0}}};
            res_flags = 3'b010;
        end else begin
            res_data  = {s2_sign, EXP_WIDTH'(e_fin), man_fin};
            res_flags = {2'b00, e_fin == 0};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_flags <= 3'b000;
        end else if (!stall) begin
            out_valid <= s2_valid;
            out_data  <= res_data;
            out_flags <= res_flags;
        end
    end

endmodule
